// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
//   Definitions shared by the data cache and the instruction cache:
//   - FSM state encoding as localparams, plus the enum built on them.
//   - Functions that derive index, offset and tag widths from the geometry.
//   No ports.
// -----------------------------------------------------------------------------
package cache_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REFILL = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        REFILL = ST_REFILL,
        WRITE  = ST_WRITE,
        RESP   = ST_RESP
    } cache_state_e;

    function automatic int calc_idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int calc_off_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    // The two low address bits select a byte within a 32-bit word.
    // Word accesses ignore them, so they belong to neither the tag nor the index.
    function automatic int calc_tag_w(input int addr_w, input int num_lines,
                                      input int words_per_line);
        return addr_w - calc_idx_w(num_lines) - calc_off_w(words_per_line) - 2;
    endfunction

endpackage

// File: rtl/cache_data_array.sv
// -----------------------------------------------------------------------------
// cache_data_array
//   Storage for a direct-mapped cache: one valid bit and one tag per line,
//   plus WORDS_PER_LINE data words per line.
//   Ports:
//     clk_i       clock, rising edge
//     rst_i       synchronous active-high reset; clears every valid bit
//     rd_idx_i    line index for the read port
//     rd_off_i    word offset for the read port
//     rd_valid_o  valid bit of the indexed line (combinational)
//     rd_tag_o    tag of the indexed line (combinational)
//     rd_data_o   indexed word (combinational)
//     wr_idx_i    line index for the writes
//     wr_off_i    word offset for the data write
//     data_we_i   write wr_data_i into the word at [wr_idx_i][wr_off_i]
//     wr_data_i   data for the word write
//     tag_we_i    write wr_tag_i to line wr_idx_i and set its valid bit
//     wr_tag_i    tag for the tag write
// -----------------------------------------------------------------------------
module cache_data_array
    import cache_pkg::*;
#(
    parameter int NUM_LINES      = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int DATA_W         = 32,
    parameter int TAG_W          = 23,
    localparam int IDX_W         = calc_idx_w(NUM_LINES),
    localparam int OFF_W         = calc_off_w(WORDS_PER_LINE)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    input  logic [OFF_W-1:0]  rd_off_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [OFF_W-1:0]  wr_off_i,
    input  logic              data_we_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              tag_we_i,
    input  logic [TAG_W-1:0]  wr_tag_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [DATA_W-1:0]    data_q [NUM_LINES][WORDS_PER_LINE];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i][rd_off_i];

    // A line becomes valid only when its tag is written. The tag is written on
    // the last refill beat, so an aborted refill leaves the line invalid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (tag_we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // NOTE: tag and data storage is deliberately not reset. Every read is
    // qualified by the valid bit, so stale contents are never observed, and a
    // reset-free array can still map onto RAM macros.
    always_ff @(posedge clk_i) begin
        if (data_we_i) begin
            data_q[wr_idx_i][wr_off_i] <= wr_data_i;
        end
        if (tag_we_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
    end

endmodule

// File: rtl/data_cache_ctrl.sv
// -----------------------------------------------------------------------------
// data_cache_ctrl
//   Direct-mapped, write-through, no-write-allocate data cache between the ALU
//   and main memory. A load hit returns data with no wait state. A load miss
//   stalls the core while the line is refilled by a burst of word reads, in
//   ascending order. Every store stalls the core while the word is written
//   through to memory.
//   Ports:
//     CLK, RST    clock (rising edge), synchronous active-high reset
//     MemRead     load request          MemWrite   store request (takes priority)
//     ALUResult   byte address          WriteData  store data
//     ReadData    load data             Stall      core must hold its inputs
//     MemReq      memory request, held until MemAck
//     MemWe       1 = write, 0 = read
//     MemAddr     word-aligned memory address
//     MemWData    memory write data     MemRData   memory read data
//     MemAck      one-cycle completion pulse, one per request
//   Optional feature (macro CACHE_STATS_EN):
//     HitCount, MissCount are saturating 32-bit counters. They count load
//     hits and load misses; stores are not counted.
// -----------------------------------------------------------------------------
module data_cache_ctrl
    import cache_pkg::*;
#(
    parameter int NUM_LINES      = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int DATA_W         = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       ALUResult,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              Stall,
    output logic              MemReq,
    output logic              MemWe,
    output logic [31:0]       MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData,
    input  logic              MemAck
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       HitCount,
    output logic [31:0]       MissCount
`endif
);

    localparam int ADDR_W = 32;
    localparam int IDX_W  = calc_idx_w(NUM_LINES);
    localparam int OFF_W  = calc_off_w(WORDS_PER_LINE);
    localparam int TAG_W  = calc_tag_w(ADDR_W, NUM_LINES, WORDS_PER_LINE);
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    // Address fields: [1:0] byte (ignored) | offset | index | tag
    logic [OFF_W-1:0] addr_off;
    logic [IDX_W-1:0] addr_idx;
    logic [TAG_W-1:0] addr_tag;

    assign addr_off = ALUResult[OFF_W+1:2];
    assign addr_idx = ALUResult[OFF_W+IDX_W+1:OFF_W+2];
    assign addr_tag = ALUResult[ADDR_W-1:OFF_W+IDX_W+2];

    cache_state_e     state_q;
    logic [OFF_W-1:0] count_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [DATA_W-1:0] read_data_q;

    logic              line_valid;
    logic [TAG_W-1:0]  line_tag;
    logic [DATA_W-1:0] line_data;
    logic              hit;
    logic              load_hit;
    logic              load_miss;
    logic              refill_ack;
    logic              write_ack;
    logic              data_we;
    logic              tag_we;
    logic [OFF_W-1:0]  wr_off;
    logic [DATA_W-1:0] wr_data;

    assign hit        = line_valid && (line_tag == addr_tag);
    // A store wins when both requests are raised, so a load needs MemWrite low.
    assign load_hit   = (state_q == IDLE) && MemRead && !MemWrite && hit;
    assign load_miss  = (state_q == IDLE) && MemRead && !MemWrite && !hit;
    // MemAck is acted on only in states that have a request outstanding.
    assign refill_ack = (state_q == REFILL) && MemAck;
    assign write_ack  = (state_q == WRITE) && MemAck;

    // Write-through without allocation: a store updates the cache only if
    // its line is already present.
    assign data_we = !RST && (refill_ack || (write_ack && hit));
    assign tag_we  = !RST && refill_ack && (count_q == LAST_WORD);
    assign wr_off  = (state_q == REFILL) ? count_q : addr_off;
    assign wr_data = (state_q == REFILL) ? MemRData : WriteData;

    cache_data_array #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .DATA_W         (DATA_W),
        .TAG_W          (TAG_W)
    ) u_array (
        .clk_i      (CLK),
        .rst_i      (RST),
        .rd_idx_i   (addr_idx),
        .rd_off_i   (addr_off),
        .rd_valid_o (line_valid),
        .rd_tag_o   (line_tag),
        .rd_data_o  (line_data),
        .wr_idx_i   (addr_idx),
        .wr_off_i   (wr_off),
        .data_we_i  (data_we),
        .wr_data_i  (wr_data),
        .tag_we_i   (tag_we),
        .wr_tag_i   (addr_tag)
    );

    // The core stalls in the request cycle itself on a store or a load miss.
    always_comb begin
        case (state_q)
            IDLE:    Stall = MemWrite || (MemRead && !hit);
            REFILL:  Stall = 1'b1;
            WRITE:   Stall = 1'b1;
            default: Stall = 1'b0;
        endcase
    end

    // NOTE: ReadData gets its default before any condition, so every path
    // assigns it and no latch is inferred.
    always_comb begin
        ReadData = read_data_q;
        if (load_hit || (state_q == RESP)) begin
            ReadData = line_data;
        end
    end

    assign MemReq   = mem_req_q;
    assign MemWe    = mem_we_q;
    assign MemWData = WriteData;
    assign MemAddr  = (state_q == WRITE) ? (ALUResult & ~32'd3)
                                         : {addr_tag, addr_idx, count_q, 2'b00};

    // NOTE: state is updated with non-blocking assignments. Every register
    // then samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            count_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            read_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (MemWrite) begin
                        state_q   <= WRITE;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b1;
                    end else if (MemRead) begin
                        if (hit) begin
                            read_data_q <= line_data;
                        end else begin
                            state_q   <= REFILL;
                            count_q   <= '0;
                            mem_req_q <= 1'b1;
                            mem_we_q  <= 1'b0;
                        end
                    end
                end
                REFILL: begin
                    // MemReq stays high across beats; each ack moves to the next word.
                    if (MemAck) begin
                        count_q <= count_q + OFF_W'(1);
                        if (count_q == LAST_WORD) begin
                            state_q   <= RESP;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (MemAck) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                RESP: begin
                    read_data_q <= line_data;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (load_hit && (hit_count_q != 32'hFFFF_FFFF)) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if (load_miss && (miss_count_q != 32'hFFFF_FFFF)) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign HitCount  = hit_count_q;
    assign MissCount = miss_count_q;
`endif

endmodule

// File: tb/tb_data_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_cache_ctrl
//   Self-checking bench for data_cache_ctrl. It has a memory responder with a
//   configurable ack delay, and a reference cache model built from the address
//   arithmetic: line = (a/16)%32, tag = a/512, word = (a/4)%4.
// -----------------------------------------------------------------------------
module tb_data_cache_ctrl;

    localparam int NUM_LINES = 32;
    localparam int WPL       = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] MemRData;
    logic        MemAck;
`ifdef CACHE_STATS_EN
    logic [31:0] HitCount;
    logic [31:0] MissCount;
`endif

    data_cache_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .MemReq    (MemReq),
        .MemWe     (MemWe),
        .MemAddr   (MemAddr),
        .MemWData  (MemWData),
        .MemRData  (MemRData),
        .MemAck    (MemAck)
`ifdef CACHE_STATS_EN
        ,
        .HitCount  (HitCount),
        .MissCount (MissCount)
`endif
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- memory responder ----------------
    logic [31:0] mem [logic [31:0]];
    int          ack_delay = 2;
    bit          stray_ack = 1'b0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_txn_t;
    mem_txn_t log_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    initial begin : memory_model
        int age;
        age      = 0;
        MemAck   = 1'b0;
        MemRData = '0;
        forever begin
            @(negedge CLK);
            MemAck = 1'b0;
            if (stray_ack) begin
                MemAck   = 1'b1;
                MemRData = $urandom;
                age      = 0;
            end else if (MemReq === 1'b1) begin
                age++;
                if (age >= ack_delay) begin
                    age    = 0;
                    MemAck = 1'b1;
                    log_q.push_back('{MemWe, MemAddr, MemWData});
                    if (MemWe === 1'b1) mem[MemAddr] = MemWData;
                    else                MemRData = mem_word(MemAddr);
                end
            end else begin
                age = 0;
            end
        end
    end

    // ---------------- reference cache model ----------------
    bit          m_valid [NUM_LINES];
    logic [31:0] m_tag   [NUM_LINES];
    logic [31:0] m_data  [NUM_LINES][WPL];
    logic [31:0] m_rd;
    int          m_hits;
    int          m_misses;

    function automatic int line_of(input logic [31:0] a);
        return int'((a / 32'd16) % NUM_LINES);
    endfunction
    function automatic int word_of(input logic [31:0] a);
        return int'((a / 32'd4) % WPL);
    endfunction
    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a / 32'd512;
    endfunction

    task automatic model_reset();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_rd     = '0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled
    // just after the falling edge.
    task automatic next_edge();
        @(posedge CLK);
        #1;
    endtask
    task automatic sample();
        @(negedge CLK);
        #1;
    endtask

    // ---------------- operations ----------------
    task automatic do_load(input logic [31:0] addr, input string name);
        int          ln;
        int          wd;
        logic [31:0] tg;
        logic [31:0] base;
        logic [31:0] exp;
        bit          exp_hit;
        bit          done;
        int          stall_cycles;
        int          bad;
        ln      = line_of(addr);
        wd      = word_of(addr);
        tg      = tag_of(addr);
        base    = addr & ~32'hF;
        exp_hit = m_valid[ln] && (m_tag[ln] == tg);
        log_q.delete();
        MemRead   = 1'b1;
        MemWrite  = 1'b0;
        ALUResult = addr;
        WriteData = $urandom;
        sample();
        n_cmp++;
        if (Stall !== (exp_hit ? 1'b0 : 1'b1)) begin
            n_err++;
            $display("FAIL %s stall_on_request: got %b expected %b", name, Stall, !exp_hit);
        end
        if (exp_hit) begin
            exp = m_data[ln][wd];
            n_cmp++;
            if (ReadData !== exp || MemReq !== 1'b0) begin
                n_err++;
                $display("FAIL %s hit_data: got %h req %b expected %h req 0", name, ReadData, MemReq, exp);
            end
            m_rd = exp;
            m_hits++;
        end else begin
            exp          = mem_word(addr & ~32'd3);
            done         = 1'b0;
            stall_cycles = 1;
            bad          = 0;
            for (int i = 0; i < 200; i++) begin
                sample();
                if (Stall !== 1'b1) begin
                    done = 1'b1;
                    break;
                end
                stall_cycles++;
                if (MemReq !== 1'b1 || MemWe !== 1'b0) bad++;
            end
            n_cmp++;
            if (!done || stall_cycles != 1 + WPL * ack_delay || bad != 0) begin
                n_err++;
                $display("FAIL %s refill_timing: got %0d stall cycles (%0d bad req) expected %0d, 0 bad",
                         name, stall_cycles, bad, 1 + WPL * ack_delay);
            end
            n_cmp++;
            if (ReadData !== exp || MemReq !== 1'b0) begin
                n_err++;
                $display("FAIL %s resp_data: got %h req %b expected %h req 0", name, ReadData, MemReq, exp);
            end
            for (int i = 0; i < WPL; i++) begin
                n_cmp++;
                if (i >= log_q.size()) begin
                    n_err++;
                    $display("FAIL %s refill_beat%0d: got no request expected read of %h", name, i, base + 32'(4 * i));
                end else if (log_q[i].we !== 1'b0 || log_q[i].addr !== base + 32'(4 * i)) begin
                    n_err++;
                    $display("FAIL %s refill_beat%0d: got we=%b addr %h expected we=0 addr %h",
                             name, i, log_q[i].we, log_q[i].addr, base + 32'(4 * i));
                end
            end
            m_valid[ln] = 1'b1;
            m_tag[ln]   = tg;
            for (int i = 0; i < WPL; i++) m_data[ln][i] = mem_word(base + 32'(4 * i));
            m_rd = exp;
            m_misses++;
        end
        next_edge();
        MemRead = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                            input bit both, input string name);
        int  ln;
        int  wd;
        bit  exp_hit;
        bit  done;
        int  bad;
        ln      = line_of(addr);
        wd      = word_of(addr);
        exp_hit = m_valid[ln] && (m_tag[ln] == tag_of(addr));
        log_q.delete();
        MemWrite  = 1'b1;
        MemRead   = both;
        ALUResult = addr;
        WriteData = data;
        sample();
        n_cmp++;
        if (Stall !== 1'b1) begin
            n_err++;
            $display("FAIL %s store_stall: got %b expected 1", name, Stall);
        end
        done = 1'b0;
        bad  = 0;
        for (int i = 0; i < 200; i++) begin
            sample();
            if (MemReq !== 1'b1 || MemWe !== 1'b1 || Stall !== 1'b1) bad++;
            if (MemAck === 1'b1) begin
                done = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!done || bad != 0) begin
            n_err++;
            $display("FAIL %s write_phase: got done=%b bad=%0d expected done=1 bad=0", name, done, bad);
        end
        next_edge();
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        sample();
        n_cmp++;
        if (Stall !== 1'b0 || MemReq !== 1'b0 || ReadData !== m_rd) begin
            n_err++;
            $display("FAIL %s after_ack: got stall %b req %b rd %h expected 0 0 %h",
                     name, Stall, MemReq, ReadData, m_rd);
        end
        n_cmp++;
        if (log_q.size() != 1) begin
            n_err++;
            $display("FAIL %s write_txn: got %0d requests expected 1", name, log_q.size());
        end else if (log_q[0].we !== 1'b1 || log_q[0].addr !== (addr & ~32'd3) || log_q[0].wdata !== data) begin
            n_err++;
            $display("FAIL %s write_txn: got we=%b %h<=%h expected we=1 %h<=%h", name,
                     log_q[0].we, log_q[0].addr, log_q[0].wdata, addr & ~32'd3, data);
        end
        if (exp_hit) m_data[ln][wd] = data;
        next_edge();
    endtask

    task automatic check_stats(input string name);
`ifdef CACHE_STATS_EN
        n_cmp++;
        if (HitCount !== 32'(m_hits) || MissCount !== 32'(m_misses)) begin
            n_err++;
            $display("FAIL %s stats: got hits %0d misses %0d expected %0d %0d",
                     name, HitCount, MissCount, m_hits, m_misses);
        end
`else
        // Without the stats feature there are no counters to compare.
        if (name.len() == 0) $display("stats check skipped");
`endif
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; ALUResult = '0; WriteData = '0;
        repeat (2) next_edge();
        sample();
        n_cmp++;
        if (Stall !== 1'b0 || MemReq !== 1'b0 || MemWe !== 1'b0 || ReadData !== 32'h0) begin
            n_err++;
            $display("FAIL reset_state: got stall %b req %b we %b rd %h expected 0 0 0 0",
                     Stall, MemReq, MemWe, ReadData);
        end
        next_edge();
        RST = 1'b0;
        model_reset();
        check_stats("reset");
    endtask

    task automatic test_refill();
        ack_delay = 2;
        do_load(32'h0000_0100, "t1_miss_0x100");
    endtask

    task automatic test_hit();
        do_load(32'h0000_0108, "t2_hit_0x108");
    endtask

    task automatic test_store_hit();
        do_store(32'h0000_0104, 32'hDEAD_BEEF, 1'b0, "t3_store_hit");
        do_load(32'h0000_0104, "t3_read_back");
    endtask

    task automatic test_store_miss();
        do_store(32'h0000_2000, 32'h1234_5678, 1'b0, "t4_store_miss");
        do_load(32'h0000_2000, "t4_read_after_miss_store");
    endtask

    task automatic test_evict();
        do_load(32'h0000_0200, "t5_read_0x200");
        // 0x300 shares index 16 with 0x100 and has a different tag.
        do_load(32'h0000_0300, "t5_conflict_0x300");
        do_load(32'h0000_0100, "t5_reread_0x100");
    endtask

    task automatic test_idle_hold();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ALUResult = $urandom;
            stray_ack = (i == 1);
            sample();
            n_cmp++;
            if (Stall !== 1'b0 || MemReq !== 1'b0 || ReadData !== m_rd) begin
                n_err++;
                $display("FAIL idle_hold%0d: got stall %b req %b rd %h expected 0 0 %h",
                         i, Stall, MemReq, ReadData, m_rd);
            end
            next_edge();
        end
        stray_ack = 1'b0;
        do_store(32'h0000_0106, 32'hCAFE_F00D, 1'b1, "both_is_store");
        do_load(32'h0000_0107, "both_read_back");
    endtask

    task automatic test_reset_mid_refill();
        int acks;
        logic [31:0] addr;
        addr      = 32'h0000_1440;
        ack_delay = 2;
        acks      = 0;
        MemRead   = 1'b1;
        MemWrite  = 1'b0;
        ALUResult = addr;
        for (int i = 0; i < 200 && acks < 2; i++) begin
            sample();
            if (MemAck === 1'b1) acks++;
        end
        next_edge();
        RST = 1'b1;
        next_edge();
        RST       = 1'b0;
        MemRead   = 1'b0;
        stray_ack = 1'b1;
        model_reset();
        sample();
        n_cmp++;
        if (acks != 2 || MemReq !== 1'b0 || Stall !== 1'b0 || ReadData !== 32'h0) begin
            n_err++;
            $display("FAIL t6_abort: got acks %0d req %b stall %b rd %h expected 2 0 0 0",
                     acks, MemReq, Stall, ReadData);
        end
        check_stats("t6_after_reset");
        next_edge();
        stray_ack = 1'b0;
        sample();
        n_cmp++;
        if (MemReq !== 1'b0 || Stall !== 1'b0) begin
            n_err++;
            $display("FAIL t6_stray_ack: got req %b stall %b expected 0 0", MemReq, Stall);
        end
        next_edge();
        do_load(addr, "t6_reread");
    endtask

    task automatic test_back_to_back();
        do_load(32'h0000_0A04, "b2b_miss");
        do_load(32'h0000_0A0C, "b2b_hit");
        do_store(32'h0000_0A08, 32'h0BAD_F00D, 1'b0, "b2b_store");
        do_load(32'h0000_0A08, "b2b_hit_after_store");
    endtask

    task automatic test_random();
        int lines [4] = '{3, 7, 16, 31};
        logic [31:0] addr;
        int kind;
        for (int n = 0; n < 120; n++) begin
            addr = (32'($urandom_range(0, 3)) << 9) | (32'(lines[$urandom_range(0, 3)]) << 4)
                 | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            ack_delay = $urandom_range(1, 3);
            kind = $urandom_range(0, 9);
            if (kind < 6)      do_load(addr, "rand_load");
            else if (kind < 9) do_store(addr, $urandom, 1'b0, "rand_store");
            else               do_store(addr, $urandom, 1'b1, "rand_both");
        end
        check_stats("random");
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_refill();
        test_hit();
        test_store_hit();
        test_store_miss();
        test_evict();
        test_idle_hold();
        test_back_to_back();
        test_reset_mid_refill();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
